pmipsl_dmem_io: RTL and testbench

//  Data-memory subsystem consumed by the PMIPSL MEM stage: word RAM plus memory-mapped I/O page.

---
 rtl/pmipsl_pkg.sv | 23 ++
 rtl/pmipsl_out_fifo.sv | 53 +++++
 rtl/pmipsl_dmem_io.sv | 126 ++++++++++++
 tb/tb_pmipsl_dmem_io.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pmipsl_pkg.sv
// Shared definitions for the PMIPSL data-memory subsystem: data word width,
// I/O page register offsets and STATUS flag placement.
package pmipsl_pkg;

   localparam int WORD_W = 16;

   // Byte offsets within the 256-byte I/O page (bit 0 is always ignored)
   localparam logic [7:0] IO_OFS_OUT    = 8'h00;
   localparam logic [7:0] IO_OFS_STATUS = 8'h02;
   localparam logic [7:0] IO_OFS_TIMER  = 8'h04;

   // STATUS flags sit directly above the count field, counted from its top.
   localparam int STAT_EMPTY_REL = 0;
   localparam int STAT_FULL_REL  = 1;
   localparam int STAT_OVF_REL   = 2;

   // The STATUS count field carries count mod FIFO_DEPTH. A full FIFO
   // therefore reads as count 0, and the full flag tells it apart from empty.
   function automatic int statusCntW(input int fifoDepth);
      return (fifoDepth <= 2) ? 1 : $clog2(fifoDepth);
   endfunction

endpackage

// File: rtl/pmipsl_out_fifo.sv
// Output FIFO for the I/O page OUT register. Storage is registered, and the
// head word is read straight from storage at the read pointer. A push into
// a full FIFO is taken only when a pop happens in the same cycle.
module pmipsl_out_fifo
   import pmipsl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WORD_W-1:0]              pushData,
   input  logic                           pop,
   output logic [WORD_W-1:0]              headData,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(FIFO_DEPTH):0]    count
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [WORD_W-1:0] storage [FIFO_DEPTH];
   logic [PW-1:0]     rdPtr;
   logic [PW-1:0]     wrPtr;
   logic [PW:0]       cnt;
   logic              popOk;
   logic              pushOk;

   assign empty    = (cnt == '0);
   assign full     = (cnt == (PW+1)'(FIFO_DEPTH));
   assign popOk    = pop & ~empty;
   assign pushOk   = push & (~full | popOk);
   assign headData = storage[rdPtr];
   assign count    = cnt;

   // Pointer, count and storage update; storage is cleared so the head reads 0 out of reset
   always_ff @(posedge clock) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         cnt   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) storage[i] <= '0;
      end else begin
         if (pushOk) begin
            storage[wrPtr] <= pushData;
            wrPtr          <= wrPtr + 1'b1;
         end
         if (popOk) rdPtr <= rdPtr + 1'b1;
         cnt <= cnt + {{PW{1'b0}}, pushOk} - {{PW{1'b0}}, popOk};
      end
   end

endmodule

// File: rtl/pmipsl_dmem_io.sv
// PMIPSL data memory: word RAM below IO_BASE plus a 256-byte I/O page holding
// OUT (FIFO push), STATUS (count/flags, write clears overflow) and TIMER.
// The read path is combinational so the core can latch it in the same cycle.
// The timer is built only when PMIPSL_DMEM_TIMER_EN is defined. Without it,
// TIMER reads as zero and writes to it are ignored.
module pmipsl_dmem_io
   import pmipsl_pkg::*;
#(
   parameter int          DEPTH      = 256,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] IO_BASE    = 16'hFF00
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [15:0]         dmemaddr,
   input  logic [WORD_W-1:0]   dmemwdata,
   input  logic                dmemwrite,
   input  logic                dmemread,
   output logic [WORD_W-1:0]   dmemrdata,
   output logic [WORD_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int RAM_AW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = statusCntW(FIFO_DEPTH);

   logic [WORD_W-1:0] ram [DEPTH];
   logic [RAM_AW-1:0] ramIdx;
   logic [16:0]       ioRel;
   logic [7:0]        ioOfs;
   logic              isRam;
   logic              isIo;
   logic              outWrite;
   logic              statusWrite;
   logic              popReq;
   logic              fifoFull;
   logic              fifoEmpty;
   logic [PW:0]       fifoCount;
   logic              ovf;
   logic [WORD_W-1:0] statusWord;
   logic [WORD_W-1:0] timerRead;
   logic              unusedBits;

   // The 17-bit offset keeps the page end (IO_BASE + 256) from wrapping
   assign ioRel       = {1'b0, dmemaddr} - {1'b0, IO_BASE};
   assign isRam       = (dmemaddr < IO_BASE);
   assign isIo        = ~isRam & (ioRel[16:8] == 9'd0);
   assign ioOfs       = {ioRel[7:1], 1'b0};
   assign ramIdx      = dmemaddr[RAM_AW:1];
   assign outWrite    = dmemwrite & isIo & (ioOfs == IO_OFS_OUT);
   assign statusWrite = dmemwrite & isIo & (ioOfs == IO_OFS_STATUS);
   assign popReq      = out_valid & out_ready;
   assign out_valid   = ~fifoEmpty;
   assign unusedBits  = ^{ioRel[0], fifoCount[PW]};

   pmipsl_out_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (outWrite),
      .pushData (dmemwdata),
      .pop      (popReq),
      .headData (out_data),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount)
   );

   // Word RAM; contents deliberately survive reset
   always_ff @(posedge clock) begin
      if (dmemwrite && isRam) ram[ramIdx] <= dmemwdata;
   end

   // Sticky overflow: a dropped push wins over a same-cycle STATUS clear
   always_ff @(posedge clock) begin
      if (reset)                                  ovf <= 1'b0;
      else if (outWrite && fifoFull && !popReq)   ovf <= 1'b1;
      else if (statusWrite)                       ovf <= 1'b0;
   end

`ifdef PMIPSL_DMEM_TIMER_EN
   logic              timerWrite;
   logic [WORD_W-1:0] timerCount;

   assign timerWrite = dmemwrite & isIo & (ioOfs == IO_OFS_TIMER);
   assign timerRead  = timerCount;

   // Free-running timer; a software load takes priority over the increment
   always_ff @(posedge clock) begin
      if (reset)           timerCount <= '0;
      else if (timerWrite) timerCount <= dmemwdata;
      else                 timerCount <= timerCount + 1'b1;
   end
`else
   assign timerRead = '0;
`endif

   // STATUS packing: count field at the bottom, flags directly above it
   always_comb begin
      statusWord                         = '0;
      statusWord[CW-1:0]                 = fifoCount[CW-1:0];
      statusWord[CW + STAT_EMPTY_REL]    = fifoEmpty;
      statusWord[CW + STAT_FULL_REL]     = fifoFull;
      statusWord[CW + STAT_OVF_REL]      = ovf;
   end

   // Combinational read mux; returns the pre-write value on a same-cycle write
   always_comb begin
      dmemrdata = '0;
      if (dmemread) begin
         if (isRam) begin
            dmemrdata = ram[ramIdx];
         end else if (isIo) begin
            case (ioOfs)
               IO_OFS_STATUS: dmemrdata = statusWord;
               IO_OFS_TIMER:  dmemrdata = timerRead;
               default:       dmemrdata = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pmipsl_dmem_io.sv
// Bench for pmipsl_dmem_io. Directed scenarios run first, then a randomized
// run. Every cycle is checked against a behavioural model built from a word
// array, a queue and a few scalars.
module tb_pmipsl_dmem_io;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] dmemaddr = '0;
   logic [15:0] dmemwdata = '0;
   logic        dmemwrite = 1'b0;
   logic        dmemread = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] dmemrdata;
   logic [15:0] out_data;
   logic        out_valid;

   int checks = 0;
   int failures = 0;

   logic [15:0] mRam [256];
   logic [15:0] mQ [$];
   bit          mOvf = 1'b0;
   logic [15:0] mTimer = '0;
   bit          modelLive = 1'b0;
   logic [15:0] lastRd;
   logic [15:0] lastOut;
   logic        lastValid;

   pmipsl_dmem_io dut (
      .clock     (clock),
      .reset     (reset),
      .dmemaddr  (dmemaddr),
      .dmemwdata (dmemwdata),
      .dmemwrite (dmemwrite),
      .dmemread  (dmemread),
      .dmemrdata (dmemrdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int ioOffset(input logic [15:0] a);
      return (int'(a) - 'hFF00) & 'hFE;
   endfunction

   function automatic logic [15:0] mRead(input logic [15:0] a, input bit re);
      int st;
      int n;
      if (!re) return 16'h0000;
      if (a < 16'hFF00) return mRam[(int'(a) / 2) % 256];
      n = mQ.size();
      case (ioOffset(a))
         2: begin
            st = (mOvf ? 16 : 0) + ((n == 4) ? 8 : 0) + ((n == 0) ? 4 : 0) + (n % 4);
            return 16'(st);
         end
`ifdef PMIPSL_DMEM_TIMER_EN
         4: return mTimer;
`endif
         default: return 16'h0000;
      endcase
   endfunction

   // One clock: drive inputs, check outputs before the edge, then advance the model.
   task automatic step(input bit rst, input logic [15:0] a, input logic [15:0] wd,
                       input bit we, input bit re, input bit rdy, input string tag);
      bit popOk;
      bit isIo;
      reset     = rst;
      dmemaddr  = a;
      dmemwdata = wd;
      dmemwrite = we;
      dmemread  = re;
      out_ready = rdy;
      #2;
      lastRd    = dmemrdata;
      lastOut   = out_data;
      lastValid = out_valid;
      if (modelLive) begin
         chk({tag, "_rd"}, dmemrdata, mRead(a, re));
         chk({tag, "_vld"}, 16'(out_valid), 16'(mQ.size() != 0));
         if (mQ.size() != 0) chk({tag, "_dat"}, out_data, mQ[0]);
      end
      isIo = (a >= 16'hFF00);
      if (rst) begin
         mQ.delete();
         mOvf      = 1'b0;
         mTimer    = 16'h0000;
         modelLive = 1'b1;
      end else begin
         popOk = rdy && (mQ.size() > 0);
         if (popOk) void'(mQ.pop_front());
         if (we && isIo && ioOffset(a) == 0) begin
            if (mQ.size() < 4) mQ.push_back(wd);
            else mOvf = 1'b1;
         end
         if (we && isIo && ioOffset(a) == 2) mOvf = 1'b0;
         if (we && isIo && ioOffset(a) == 4) mTimer = wd;
         else mTimer = mTimer + 16'd1;
         if (we && !isIo) mRam[(int'(a) / 2) % 256] = wd;
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [15:0] words [5];
      logic [15:0] a;
      bit          we;
      bit          re;
      int          c;
      words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;
      words[3] = 16'hDDDD; words[4] = 16'hEEEE;

      step(1, 16'h0000, 16'h0000, 0, 0, 0, "rst0");
      step(1, 16'h0000, 16'h0000, 0, 0, 0, "rst1");

      // 1: RAM write then read, odd address aliases the same word
      step(0, 16'h0010, 16'h1234, 1, 0, 0, "t1w");
      step(0, 16'h0010, 16'h0000, 0, 1, 0, "t1r0");
      chk("t1_word", lastRd, 16'h1234);
      step(0, 16'h0011, 16'h0000, 0, 1, 0, "t1r1");
      chk("t1_odd", lastRd, 16'h1234);

      // 2: fill FIFO, overflow, drain
      for (int i = 0; i < 4; i++) step(0, 16'hFF00, words[i], 1, 0, 0, "t2push");
      step(0, 16'hFF02, 16'h0000, 0, 1, 0, "t2st");
      chk("t2_full", lastRd, 16'h0008);
      step(0, 16'hFF00, words[4], 1, 0, 0, "t2ovf");
      step(0, 16'hFF02, 16'h0000, 0, 1, 0, "t2st2");
      chk("t2_ovf", lastRd, 16'h0018);
      for (int i = 0; i < 4; i++) begin
         step(0, 16'h0000, 16'h0000, 0, 0, 1, "t2drain");
         chk("t2_head", lastOut, words[i]);
      end
      step(0, 16'h0000, 16'h0000, 0, 0, 1, "t2done");
      chk("t2_empty", 16'(lastValid), 16'h0000);

      // 6: no read enable gives zero; STATUS write clears the sticky overflow
      step(0, 16'hFF02, 16'h0000, 0, 1, 0, "t6st");
      chk("t6_ovf_held", lastRd, 16'h0014);
      step(0, 16'h0020, 16'hBEEF, 1, 0, 0, "t6w");
      step(0, 16'h0020, 16'h0000, 0, 0, 0, "t6nore");
      chk("t6_nore", lastRd, 16'h0000);
      step(0, 16'hFF02, 16'h5A5A, 1, 0, 0, "t6clr");
      step(0, 16'hFF02, 16'h0000, 0, 1, 0, "t6st2");
      chk("t6_cleared", lastRd, 16'h0004);

      // 3: full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(0, 16'hFF00, words[i], 1, 0, 0, "t3push");
      step(0, 16'hFF00, 16'h7777, 1, 0, 1, "t3both");
      step(0, 16'hFF02, 16'h0000, 0, 1, 0, "t3st");
      chk("t3_status", lastRd, 16'h0008);
      for (int i = 0; i < 4; i++) step(0, 16'h0000, 16'h0000, 0, 0, 1, "t3drain");
      chk("t3_last", lastOut, 16'h7777);

      // 4: timer load near the top and wrap
      step(0, 16'hFF04, 16'hFFFE, 1, 0, 0, "t4w");
      step(0, 16'h0000, 16'h0000, 0, 0, 0, "t4i0");
      step(0, 16'h0000, 16'h0000, 0, 0, 0, "t4i1");
      step(0, 16'hFF04, 16'h0000, 0, 1, 0, "t4r");
      chk("t4_wrap", lastRd, 16'h0000);

      // 5: reset while FIFO holds data and consumer is ready
      step(0, 16'h0040, 16'hCAFE, 1, 0, 0, "t5w");
      step(0, 16'hFF00, 16'h0101, 1, 0, 0, "t5p0");
      step(0, 16'hFF00, 16'h0202, 1, 0, 0, "t5p1");
      step(1, 16'h0000, 16'h0000, 0, 0, 1, "t5rst");
      step(0, 16'hFF04, 16'h0000, 0, 1, 1, "t5tim");
      chk("t5_timer", lastRd, 16'h0000);
      chk("t5_valid", 16'(lastValid), 16'h0000);
      chk("t5_data", lastOut, 16'h0000);
      step(0, 16'hFF02, 16'h0000, 0, 1, 0, "t5st");
      chk("t5_status", lastRd, 16'h0004);
      step(0, 16'h0040, 16'h0000, 0, 1, 0, "t5ram");
      chk("t5_ram", lastRd, 16'hCAFE);

      // Populate every RAM word so random reads always have a known value
      for (int i = 0; i < 256; i++)
         step(0, 16'(i * 2), 16'($urandom), 1, 0, 0, "fill");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         c  = $urandom_range(0, 6);
         we = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 1) == 1);
         case (c)
            0, 1: a = 16'($urandom_range(0, 16'hFEFF));
            2:    a = 16'h0000 | 16'(16'hFF00 + $urandom_range(0, 1));
            3:    begin a = 16'(16'hFF00 + $urandom_range(0, 1)); we = 1'b1; end
            4:    begin a = 16'(16'hFF02 + $urandom_range(0, 1)); we = ($urandom_range(0, 4) == 0); end
            5:    a = 16'(16'hFF04 + $urandom_range(0, 1));
            default: a = 16'(16'hFF06 + $urandom_range(0, 16'hF9));
         endcase
         if ($urandom_range(0, 59) == 0)
            step(1, a, 16'($urandom), 0, re, $urandom_range(0, 1) == 1, "rrst");
         else
            step(0, a, 16'($urandom), we, re, $urandom_range(0, 2) == 0, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
